// File: rtl/image_loader.sv
// image_loader: packs an 8-bit valid/ready byte stream into DATA_W-bit words
// and writes them through memory port B at sequential word addresses.
module image_loader #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 64,
  parameter int ADDR_STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_words,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] addressB,
  output logic [DATA_W-1:0] inputDataB,
  output logic              writeB,
  output logic              busy,
  output logic              done
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       word_total;
  logic [15:0]       words_written;
  logic [IDX_W-1:0]  byte_idx;
  logic [DATA_W-1:0] shift_buf;
  logic [DATA_W-1:0] packed_word;
  logic              start_ok;
  logic              byte_ok;
  logic              word_full;
  logic              last_word;

  assign start_ok  = (state == IDLE) && start;
  assign byte_ok   = in_valid && in_ready;
  assign word_full = byte_ok && (byte_idx == LAST_IDX);
  assign last_word = (words_written + 16'd1) == word_total;

  // The incoming byte drops into its lane so the completed word is ready on the 8th accept.
  always_comb begin
    packed_word = shift_buf;
    packed_word[byte_idx*8 +: 8] = in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (num_words == 16'd0) ? DONE : LOAD;
      LOAD:    if (word_full) state_next = WRITE;
      WRITE:   state_next = last_word ? DONE : LOAD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == LOAD);
    writeB   = (state == WRITE);
    busy     = (state != IDLE);
    done     = (state == DONE);
  end

  // Port-B address/data are only loaded when a word completes, so they hold through DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr          <= '0;
      word_total    <= '0;
      words_written <= '0;
      byte_idx      <= '0;
      shift_buf     <= '0;
      addressB      <= '0;
      inputDataB    <= '0;
    end else begin
      if (start_ok) begin
        addr          <= base_addr;
        word_total    <= num_words;
        words_written <= '0;
        byte_idx      <= '0;
        shift_buf     <= '0;
      end
      if (byte_ok) begin
        shift_buf <= packed_word;
        byte_idx  <= word_full ? '0 : byte_idx + 1'b1;
        if (word_full) begin
          addressB   <= addr;
          inputDataB <= packed_word;
        end
      end
      if (state == WRITE) begin
        addr          <= addr + STEP;
        words_written <= words_written + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// Self-checking bench for image_loader: per-cycle behavioural model of the
// control outputs plus a byte-stream scoreboard for every port-B write.
module tb_image_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] num_words;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] addressB;
  logic [63:0] inputDataB;
  logic        writeB;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Bytes the driver handed over, in order, and the addresses the loads must hit.
  logic [7:0]  stream_q[$];
  logic [15:0] exp_addr_q[$];
  logic [15:0] wr_addr_log[$];
  logic [63:0] wr_data_log[$];

  // Model expectations for the current cycle.
  bit          e_busy  = 1'b0;
  bit          e_ready = 1'b0;
  bit          e_write = 1'b0;
  bit          e_done  = 1'b0;
  logic [15:0] e_addr  = '0;
  logic [63:0] e_data  = '0;
  logic [7:0]  m_bytes[$];
  int          m_left  = 0;
  logic [15:0] m_addr  = '0;

  image_loader #(.ADDR_W(16), .DATA_W(64), .ADDR_STEP(1)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_words(num_words), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .addressB(addressB), .inputDataB(inputDataB),
    .writeB(writeB), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pack_word(input logic [7:0] q[$], input logic [7:0] last);
    logic [63:0] w = '0;
    for (int k = 0; k < q.size(); k++) w[8*k +: 8] = q[k];
    w[56 +: 8] = last;
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a load is a sequence of 8-byte words, each followed by one
  // write cycle, and the whole load is followed by one done cycle.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      e_busy = 0; e_ready = 0; e_write = 0; e_done = 0;
      e_addr = '0; e_data = '0; m_bytes.delete(); m_left = 0; m_addr = '0;
    end else if (e_done) begin
      e_done = 0; e_busy = 0;
    end else if (e_write) begin
      e_write = 0;
      m_left--;
      m_addr = m_addr + 16'd1;
      if (m_left == 0) e_done = 1;
      else e_ready = 1;
    end else if (!e_busy) begin
      if (start) begin
        e_busy = 1; m_addr = base_addr; m_left = int'(num_words);
        if (num_words == 16'd0) e_done = 1;
        else e_ready = 1;
      end
    end else if (e_ready && in_valid) begin
      if (m_bytes.size() == 7) begin
        e_data = pack_word(m_bytes, in_data);
        e_addr = m_addr;
        e_write = 1; e_ready = 0;
        m_bytes.delete();
      end else begin
        m_bytes.push_back(in_data);
      end
    end
  end

  // Compare process: every cycle, sampled away from the rising edge.
  initial begin
    logic [63:0] w;
    logic [15:0] a;
    forever begin
      @(negedge clk);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("writeB", writeB, e_write);
      chk("in_ready", in_ready, e_ready);
      chk("addressB", addressB, e_addr);
      chk("inputDataB", inputDataB, e_data);
      if (writeB === 1'b1) begin
        wr_addr_log.push_back(addressB);
        wr_data_log.push_back(inputDataB);
        checks++;
        if (stream_q.size() < 8 || exp_addr_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write at %0t: got addr %0h, stream bytes %0d, pending addrs %0d",
                   $time, addressB, stream_q.size(), exp_addr_q.size());
        end else begin
          w = '0;
          for (int k = 0; k < 8; k++) w[8*k +: 8] = stream_q.pop_front();
          a = exp_addr_q.pop_front();
          chk("sb_data", inputDataB, w);
          chk("sb_addr", addressB, a);
        end
      end
    end
  end

  task automatic start_load(input logic [15:0] b, input logic [15:0] n, input bit taken);
    base_addr = b; num_words = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (taken) for (int i = 0; i < int'(n); i++) exp_addr_q.push_back(b + 16'(i));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    in_data = b; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("[TB] FAIL handshake_timeout: in_ready=%0b required 1", in_ready);
    end else begin
      stream_q.push_back(b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_random(input int nbytes, input int max_gap);
    for (int i = 0; i < nbytes; i++) send_byte(8'($urandom), int'($urandom_range(0, max_gap)));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s done_timeout: done=%0b required 1", tag, done);
    end
    @(negedge clk);
  endtask

  task automatic clear_logs();
    wr_addr_log.delete();
    wr_data_log.delete();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    in_data = '0; in_valid = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_writeB", writeB, 0);
    chk("rst_inputDataB", inputDataB, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single word, back-to-back bytes 01..08.
    clear_logs();
    start_load(16'h0100, 16'd1, 1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 0);
    wait_done("single");
    chk("single_count", wr_addr_log.size(), 1);
    if (wr_addr_log.size() == 1) begin
      chk("single_addr", wr_addr_log[0], 16'h0100);
      chk("single_data", wr_data_log[0], 64'h0807060504030201);
    end

    // Reset in the middle of a word: partial word discarded, outputs cleared.
    clear_logs();
    start_load(16'h0200, 16'd1, 0);
    for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i), 0);
    #2 reset = 1'b0;
    stream_q.delete();
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_addressB", addressB, 0);
    chk("midrst_inputDataB", inputDataB, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_no_write", wr_addr_log.size(), 0);

    // Three words with random valid gaps.
    clear_logs();
    start_load(16'h0100, 16'd3, 1);
    send_random(24, 3);
    wait_done("gaps");
    chk("gaps_count", wr_addr_log.size(), 3);
    if (wr_addr_log.size() == 3) begin
      chk("gaps_addr0", wr_addr_log[0], 16'h0100);
      chk("gaps_addr1", wr_addr_log[1], 16'h0101);
      chk("gaps_addr2", wr_addr_log[2], 16'h0102);
    end

    // Zero-length load.
    clear_logs();
    start_load(16'h0400, 16'd0, 1);
    chk("zero_done", done, 1);
    wait_done("zero");
    chk("zero_no_write", wr_addr_log.size(), 0);

    // Address wrap.
    clear_logs();
    start_load(16'hFFFF, 16'd2, 1);
    send_random(16, 1);
    wait_done("wrap");
    chk("wrap_count", wr_addr_log.size(), 2);
    if (wr_addr_log.size() == 2) begin
      chk("wrap_addr0", wr_addr_log[0], 16'hFFFF);
      chk("wrap_addr1", wr_addr_log[1], 16'h0000);
    end

    // Start re-pulsed during LOAD must be ignored.
    clear_logs();
    start_load(16'h0300, 16'd2, 1);
    send_random(3, 0);
    start_load(16'h0500, 16'd4, 0);
    send_random(13, 2);
    wait_done("restart");
    chk("restart_count", wr_addr_log.size(), 2);
    if (wr_addr_log.size() == 2) begin
      chk("restart_addr0", wr_addr_log[0], 16'h0300);
      chk("restart_addr1", wr_addr_log[1], 16'h0301);
    end

    // A few fully random loads.
    for (int t = 0; t < 3; t++) begin
      logic [15:0] b;
      int n;
      b = 16'($urandom);
      n = int'($urandom_range(1, 3));
      start_load(b, 16'(n), 1);
      send_random(8 * n, 2);
      wait_done("random");
    end

    repeat (3) @(negedge clk);
    chk("stream_leftover", stream_q.size(), 0);
    chk("addr_leftover", exp_addr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
